// File: rtl/cv32e40s_pkg.sv
// Shared definitions for the hardened state register bank.
// Holds the helper that slices a per-channel reset value out of a packed vector.
package cv32e40s_pkg;

   localparam int unsigned SREG_MAX_W    = 64;
   localparam int unsigned SREG_MAX_BITS = 1024;

   // Channel ch of a packed vector of w-bit fields, zero-extended to SREG_MAX_W
   function automatic logic [SREG_MAX_W-1:0] sreg_rv_slice(
      input logic [SREG_MAX_BITS-1:0] rv,
      input int unsigned              ch,
      input int unsigned              w
   );
      logic [SREG_MAX_BITS-1:0] sh;
      logic [SREG_MAX_W-1:0]    mask;
      sh   = rv >> (ch * w);
      mask = (w >= SREG_MAX_W) ? '1 :
             ((SREG_MAX_W'(1) << w) - SREG_MAX_W'(1));
      return sh[SREG_MAX_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/cv32e40s_hardened_sreg_ch.sv
// One hardened channel: main copy, complemented shadow copy,
// gated write and a continuous main/shadow compare.
module cv32e40s_hardened_sreg_ch
   import cv32e40s_pkg::*;
#(
   parameter int unsigned      WIDTH          = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE_CH = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] q_o,
   output logic             mism_o
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] shadow_q;
   logic             wr;

   assign wr = we_i & en_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= RESET_VALUE_CH;
      end else if (wr) begin
         main_q <= wdata_i;
      end
   end

   // Kept in its own process so the two copies stay distinct registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= ~RESET_VALUE_CH;
      end else if (wr) begin
         shadow_q <= ~wdata_i;
      end
   end

   assign q_o    = main_q;
   assign mism_o = |(main_q ^ ~shadow_q);

endmodule

// File: rtl/cv32e40s_hardened_sreg_bank.sv
// Bank of NUM_CH hardened state registers with write lock,
// registered mismatch alerts, sticky alert and locked-write error pulse.
module cv32e40s_hardened_sreg_bank
   import cv32e40s_pkg::*;
#(
   parameter int unsigned               NUM_CH      = 4,
   parameter int unsigned               WIDTH       = 8,
   parameter logic [NUM_CH*WIDTH-1:0]   RESET_VALUE = '1,
   parameter bit                        LOCKABLE    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       we_i,
   input  logic [NUM_CH*WIDTH-1:0] wdata_i,
   input  logic                    lock_i,
   output logic [NUM_CH*WIDTH-1:0] q_o,
   output logic                    locked_o,
   output logic                    locked_wr_err_o,
   output logic                    alert_o,
   output logic [NUM_CH-1:0]       alert_ch_o,
   output logic                    alert_sticky_o
);

   logic              locked_q;
   logic              err_q;
   logic [NUM_CH-1:0] mism;
   logic [NUM_CH-1:0] alert_ch_q;
   logic              sticky_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [SREG_MAX_W-1:0] RV_SL =
         sreg_rv_slice(SREG_MAX_BITS'(RESET_VALUE), c, WIDTH);

      cv32e40s_hardened_sreg_ch #(
         .WIDTH          (WIDTH),
         .RESET_VALUE_CH (RV_SL[WIDTH-1:0])
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .we_i    (we_i[c]),
         .en_i    (~locked_q),
         .wdata_i (wdata_i[c*WIDTH +: WIDTH]),
         .q_o     (q_o[c*WIDTH +: WIDTH]),
         .mism_o  (mism[c])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
      end else if (LOCKABLE && lock_i) begin
         locked_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         alert_ch_q <= '0;
         sticky_q   <= 1'b0;
      end else begin
         err_q      <= locked_q & (|we_i);
         alert_ch_q <= mism;
         sticky_q   <= sticky_q | (|mism);
      end
   end

   assign locked_o        = locked_q;
   assign locked_wr_err_o = err_q;
   assign alert_ch_o      = alert_ch_q;
   assign alert_o         = |alert_ch_q;
   assign alert_sticky_o  = sticky_q;

endmodule

// File: tb/tb_cv32e40s_hardened_sreg_bank.sv
// Directed and random bench for the hardened state register bank,
// checked against a per-channel array model.
module tb_cv32e40s_hardened_sreg_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  we_i = '0;
   logic [31:0] wdata_i = '0;
   logic        lock_i = 1'b0;
   logic [31:0] q_o;
   logic        locked_o, locked_wr_err_o, alert_o, alert_sticky_o;
   logic [3:0]  alert_ch_o;

   logic [1:0]  we_n = '0;
   logic [7:0]  wd_n = '0;
   logic        lk_n = 1'b0;
   logic [7:0]  q_n;
   logic        locked_n, err_n, alert_n, sticky_n;
   logic [1:0]  alert_ch_n;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] m_ch [4];
   logic       m_locked;
   logic       m_err;

   always #5 clk = ~clk;

   cv32e40s_hardened_sreg_bank dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .we_i            (we_i),
      .wdata_i         (wdata_i),
      .lock_i          (lock_i),
      .q_o             (q_o),
      .locked_o        (locked_o),
      .locked_wr_err_o (locked_wr_err_o),
      .alert_o         (alert_o),
      .alert_ch_o      (alert_ch_o),
      .alert_sticky_o  (alert_sticky_o)
   );

   cv32e40s_hardened_sreg_bank #(
      .NUM_CH      (2),
      .WIDTH       (4),
      .RESET_VALUE (8'h5A),
      .LOCKABLE    (1'b0)
   ) dut_nl (
      .clk             (clk),
      .rst_n           (rst_n),
      .we_i            (we_n),
      .wdata_i         (wd_n),
      .lock_i          (lk_n),
      .q_o             (q_n),
      .locked_o        (locked_n),
      .locked_wr_err_o (err_n),
      .alert_o         (alert_n),
      .alert_ch_o      (alert_ch_n),
      .alert_sticky_o  (sticky_n)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_q();
      return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
   endfunction

   function automatic logic [31:0] shadow_all();
      return {dut.g_ch[3].u_ch.shadow_q, dut.g_ch[2].u_ch.shadow_q,
              dut.g_ch[1].u_ch.shadow_q, dut.g_ch[0].u_ch.shadow_q};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) m_ch[c] = 8'hFF;
      m_locked = 1'b0;
      m_err    = 1'b0;
   endtask

   // Drive one cycle at negedge, advance the model at posedge, check at negedge
   task automatic step(input string tag, input logic [3:0] we,
                       input logic [31:0] wd, input logic lk);
      we_i = we; wdata_i = wd; lock_i = lk;
      @(posedge clk);
      m_err = m_locked && (we != 4'b0);
      if (!m_locked)
         for (int c = 0; c < 4; c++)
            if (we[c]) m_ch[c] = wd[c*8 +: 8];
      if (lk) m_locked = 1'b1;
      @(negedge clk);
      chk({tag, ".q"}, 64'(q_o), 64'(model_q()));
      chk({tag, ".locked"}, 64'(locked_o), 64'(m_locked));
      chk({tag, ".err"}, 64'(locked_wr_err_o), 64'(m_err));
      chk({tag, ".alert"}, 64'({alert_o, alert_ch_o}), 64'(0));
      we_i = '0; lock_i = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst.q", 64'(q_o), 64'(32'hFFFF_FFFF));
      chk("rst.shadow", 64'(shadow_all()), 64'(0));
      chk("rst.outs", 64'({locked_o, locked_wr_err_o, alert_o,
                           alert_ch_o, alert_sticky_o}), 64'(0));
      chk("rst.nl_q", 64'(q_n), 64'(8'h5A));
      @(negedge clk);
      rst_n = 1'b1;

      step("wr0101", 4'b0101, 32'h1122_3344, 1'b0);
      chk("wr0101.abs", 64'(q_o), 64'(32'hFF22_FF44));
      step("idle0", 4'b0000, 32'hDEAD_BEEF, 1'b0);
      chk("wr0101.shadow", 64'(shadow_all()), 64'(32'h00DD_00BB));

      // Corrupt the ch1 shadow and expect a one-cycle-late alert
      force dut.g_ch[1].u_ch.shadow_q = 8'h01;
      @(posedge clk);
      @(negedge clk);
      chk("flip.alert_ch", 64'(alert_ch_o), 64'(4'b0010));
      chk("flip.alert_o", 64'(alert_o), 64'(1));
      chk("flip.sticky", 64'(alert_sticky_o), 64'(1));
      release dut.g_ch[1].u_ch.shadow_q;
      we_i = 4'b0010; wdata_i = 32'h0000_3C00;
      @(posedge clk);
      m_ch[1] = 8'h3C;
      @(negedge clk);
      we_i = '0;
      repeat (2) @(negedge clk);
      chk("fix.alert_ch", 64'({alert_o, alert_ch_o}), 64'(0));
      chk("fix.sticky", 64'(alert_sticky_o), 64'(1));
      chk("fix.q", 64'(q_o), 64'(model_q()));
      chk("fix.shadow1", 64'(dut.g_ch[1].u_ch.shadow_q), 64'(8'hC3));

      step("lock_wr", 4'b0100, 32'h00A5_0000, 1'b1);
      chk("lock_wr.ch2", 64'(q_o[23:16]), 64'(8'hA5));
      step("locked_wr", 4'b0100, 32'h0000_0000, 1'b0);
      step("err_clr", 4'b0000, 32'h0, 1'b1);
      step("locked_all", 4'b1111, 32'h0123_4567, 1'b0);

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.q", 64'(q_o), 64'(32'hFFFF_FFFF));
      chk("arst.outs", 64'({locked_o, locked_wr_err_o, alert_o,
                            alert_ch_o, alert_sticky_o}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 4'b1111, 32'hCAFE_F00D, 1'b0);
      chk("post_rst.sticky", 64'(alert_sticky_o), 64'(0));

      // Lock input has no effect when locking is not built in
      lk_n = 1'b1;
      @(negedge clk);
      chk("nl.locked", 64'(locked_n), 64'(0));
      we_n = 2'b10; wd_n = 8'h3C;
      @(negedge clk);
      we_n = '0; lk_n = 1'b0;
      chk("nl.q", 64'(q_n), 64'(8'h3A));
      chk("nl.err", 64'({locked_n, err_n}), 64'(0));
      @(negedge clk);
      chk("nl.err2", 64'({err_n, alert_n, sticky_n}), 64'(0));

      for (int i = 0; i < 160; i++) begin
         if (i == 80) begin
            rst_n = 1'b0;
            #1 model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         step("rnd", 4'($urandom), $urandom,
              ($urandom_range(0, 29) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
